// File: rtl/vga_rx.sv
// vga_rx: recovers 640x480@60 VGA timing from the sync inputs and reports
// per-pixel coordinates and lit flags, plus a lit-pixel count per complete frame.
// Optional feature: define VGA_RX_TIMING_CHECK_EN to enable timing-violation
// checks (err_count and forced loss of lock). When the macro is undefined,
// err_count is tied to 0 and lock is lost only on reset.
// The timing parameters default to the standard 640x480 geometry.
module vga_rx #(
  parameter logic [9:0] H_ACTIVE     = 10'd640,
  parameter logic [9:0] H_SYNC_START = 10'd656,
  parameter logic [9:0] H_TOTAL      = 10'd800,
  parameter logic [9:0] V_ACTIVE     = 10'd480,
  parameter logic [9:0] V_SYNC_START = 10'd490,
  parameter logic [9:0] V_TOTAL      = 10'd525
`ifdef VGA_RX_TIMING_CHECK_EN
  ,
  parameter logic [9:0] H_SYNC_END   = 10'd752,
  parameter logic [9:0] V_SYNC_END   = 10'd492
`endif
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic [11:0] vga_colors,
  input  logic        vga_hs,
  input  logic        vga_vs,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_col,
  output logic [9:0]  pix_row,
  output logic        pix_on,
  output logic        frame_done,
  output logic [18:0] frame_lit,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    HLOCK    = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [9:0] H_LAST = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST = V_TOTAL - 10'd1;
  localparam logic [9:0] H_ACT_LAST = H_ACTIVE - 10'd1;
  localparam logic [9:0] V_ACT_LAST = V_ACTIVE - 10'd1;

  state_t      state, state_nxt;

  logic [11:0] colors_p0;
  logic        hs_p0, vs_p0;

  logic        hs_p1, vs_p1, lit_p1;
  logic [9:0]  col_p1, row_p1;

  logic [9:0]  col_pred, row_pred, col_nxt, row_nxt;
  logic        hs_fall, vs_fall;
  logic        viol;

  logic        vld_p2, on_p2, lock_p2;
  logic [9:0]  col_p2, row_p2;

  logic        first_px, last_px;
  logic [18:0] acc, acc_sum;
  logic        frame_ok;
  logic        done_p3;
  logic [18:0] lit_p3;

  // ---- Stage p0: single input register; all detection uses these samples ----
  // Capture the raw VGA inputs.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      colors_p0 <= '0;
      hs_p0     <= 1'b0;
      vs_p0     <= 1'b0;
    end else begin
      colors_p0 <= vga_colors;
      hs_p0     <= vga_hs;
      vs_p0     <= vga_vs;
    end
  end

  // Predict the coordinate of the p0 sample from the previous one, then apply
  // the sync reloads. hs_p1/vs_p1 hold the previous sample for edge detection.
  always_comb begin
    col_pred = (col_p1 == H_LAST) ? 10'd0 : col_p1 + 10'd1;
    row_pred = row_p1;
    if (col_p1 == H_LAST) begin
      row_pred = (row_p1 == V_LAST) ? 10'd0 : row_p1 + 10'd1;
    end
    hs_fall = hs_p1 & ~hs_p0;
    vs_fall = vs_p1 & ~vs_p0;
    // Both reloads are independent, so a coincident hs/vs fall applies both.
    col_nxt = hs_fall ? H_SYNC_START : col_pred;
    row_nxt = (vs_fall && (state != UNLOCKED)) ? V_SYNC_START : row_pred;
  end

`ifdef VGA_RX_TIMING_CHECK_EN
  logic       hs_rise, vs_rise, lit_p0;
  logic [7:0] err_q;

  // Flag any sync edge or lit sample that disagrees with the recovered timing.
  always_comb begin
    hs_rise = ~hs_p1 & hs_p0;
    vs_rise = ~vs_p1 & vs_p0;
    lit_p0  = |colors_p0;
    viol    = 1'b0;
    if (state != UNLOCKED) begin
      if (hs_fall && (col_pred != H_SYNC_START)) viol = 1'b1;
      if (hs_rise && (col_pred != H_SYNC_END))   viol = 1'b1;
      if (state == LOCKED) begin
        if (vs_fall && ((row_pred != V_SYNC_START) || (col_pred != 10'd0))) viol = 1'b1;
        if (vs_rise && ((row_pred != V_SYNC_END) || (col_pred != 10'd0)))   viol = 1'b1;
        if (lit_p0 && ((col_nxt >= H_ACTIVE) || (row_nxt >= V_ACTIVE)))     viol = 1'b1;
      end
    end
  end

  // Saturating count of flagged violations.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'd0;
    end else if (viol && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign viol      = 1'b0;
  assign err_count = 8'd0;
`endif

  // Lock FSM next state: hs fall gives column lock, vs fall gives full lock,
  // any violation drops straight back to UNLOCKED.
  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED: if (hs_fall) state_nxt = HLOCK;
      HLOCK:    if (vs_fall) state_nxt = LOCKED;
      LOCKED:   state_nxt = LOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
    if (viol) state_nxt = UNLOCKED;
  end

  // ---- Stage p1: recovered coordinate and lock state per sample ----
  // FSM state, coordinate counters and the delayed sample.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= UNLOCKED;
      col_p1 <= 10'd0;
      row_p1 <= 10'd0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      lit_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      col_p1 <= col_nxt;
      row_p1 <= row_nxt;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      lit_p1 <= |colors_p0;
    end
  end

  assign locked = (state == LOCKED);

  // ---- Stage p2: registered pixel outputs ----
  // Qualify the sample against the active area and lock state.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      on_p2   <= 1'b0;
      lock_p2 <= 1'b0;
      col_p2  <= 10'd0;
      row_p2  <= 10'd0;
    end else begin
      vld_p2  <= (state == LOCKED) && (col_p1 < H_ACTIVE) && (row_p1 < V_ACTIVE);
      on_p2   <= (state == LOCKED) && (col_p1 < H_ACTIVE) && (row_p1 < V_ACTIVE) && lit_p1;
      lock_p2 <= (state == LOCKED);
      col_p2  <= col_p1;
      row_p2  <= row_p1;
    end
  end

  assign pix_valid = vld_p2;
  assign pix_on    = on_p2;
  assign pix_col   = col_p2;
  assign pix_row   = row_p2;

  // Running lit count; pixel (0,0) restarts it so the sum includes that pixel.
  always_comb begin
    first_px = vld_p2 && (col_p2 == 10'd0) && (row_p2 == 10'd0);
    last_px  = vld_p2 && (col_p2 == H_ACT_LAST) && (row_p2 == V_ACT_LAST);
    acc_sum  = (first_px ? 19'd0 : acc) + {18'd0, on_p2};
  end

  // ---- Stage p3: frame accounting ----
  // A frame counts only if lock held from (0,0) through the last active pixel.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= 19'd0;
      frame_ok <= 1'b0;
      done_p3  <= 1'b0;
      lit_p3   <= 19'd0;
    end else begin
      done_p3 <= 1'b0;
      if (!lock_p2) begin
        acc      <= 19'd0;
        frame_ok <= 1'b0;
      end else if (vld_p2) begin
        acc <= acc_sum;
        if (first_px) frame_ok <= 1'b1;
        if (last_px && (frame_ok || first_px)) begin
          done_p3 <= 1'b1;
          lit_p3  <= acc_sum;
        end
      end
    end
  end

  assign frame_done = done_p3;
  assign frame_lit  = lit_p3;

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed bench for vga_rx using a reduced frame geometry
// (26x14 total, 16x8 active) so that many full frames fit in a short run.
module tb_vga_rx;

  localparam int HA_I  = 16;
  localparam int HSS_I = 18;
  localparam int HSE_I = 22;
  localparam int HT_I  = 26;
  localparam int VA_I  = 8;
  localparam int VSS_I = 10;
  localparam int VSE_I = 12;
  localparam int VT_I  = 14;
  localparam int FRAME_CYC = HT_I * VT_I;
  localparam int ACTIVE_PIX = HA_I * VA_I;

  logic        clk_25 = 1'b0;
  logic        rst_n;
  logic [11:0] vga_colors;
  logic        vga_hs, vga_vs;
  logic        locked, pix_valid, pix_on, frame_done;
  logic [9:0]  pix_col, pix_row;
  logic [18:0] frame_lit;
  logic [7:0]  err_count;

  always #5 clk_25 = ~clk_25;

  vga_rx #(
    .H_ACTIVE    (10'(HA_I)),
    .H_SYNC_START(10'(HSS_I)),
    .H_TOTAL     (10'(HT_I)),
    .V_ACTIVE    (10'(VA_I)),
    .V_SYNC_START(10'(VSS_I)),
    .V_TOTAL     (10'(VT_I))
`ifdef VGA_RX_TIMING_CHECK_EN
    ,
    .H_SYNC_END  (10'(HSE_I)),
    .V_SYNC_END  (10'(VSE_I))
`endif
  ) dut (
    .clk_25    (clk_25),
    .rst_n     (rst_n),
    .vga_colors(vga_colors),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs),
    .locked    (locked),
    .pix_valid (pix_valid),
    .pix_col   (pix_col),
    .pix_row   (pix_row),
    .pix_on    (pix_on),
    .frame_done(frame_done),
    .frame_lit (frame_lit),
    .err_count (err_count)
  );

  typedef struct {
    int mode;
    int a;
    int b;
    int exp_lit;
  } vec_t;

  vec_t vecs [8];

  int n_chk = 0;
  int n_pass = 0;

  // Cumulative observations, written only by the monitor.
  int cyc = 0;
  int val_cnt = 0, on_cnt = 0, stray_cnt = 0, fd_cnt = 0, unl_cnt = 0;
  int on_col = 0, on_row = 0, on_cyc = 0, fd_cyc = 0, fd_lit = 0;

  // Per-frame baselines, written only by the main sequence.
  int b_val, b_on, b_stray, b_fd, b_unl;
  int mark_cyc = 0;
  int prev_fd_cyc = 0;

  always @(posedge clk_25) cyc <= cyc + 1;

  always @(negedge clk_25) begin
    if (pix_valid) val_cnt <= val_cnt + 1;
    if (pix_on) begin
      on_cnt <= on_cnt + 1;
      on_col <= int'(pix_col);
      on_row <= int'(pix_row);
      on_cyc <= cyc;
    end
    if (pix_on && !pix_valid) stray_cnt <= stray_cnt + 1;
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
      fd_lit <= int'(frame_lit);
    end
    if (!locked) unl_cnt <= unl_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic snap();
    b_val   = val_cnt;
    b_on    = on_cnt;
    b_stray = stray_cnt;
    b_fd    = fd_cnt;
    b_unl   = unl_cnt;
  endtask

  function automatic bit lit_at(int mode, int c, int r, int a, int b);
    bit act = (c < HA_I) && (r < VA_I);
    case (mode)
      1:       return (c == a) && (r == b);
      2:       return act;
      3:       return act && (((c + r) % 2) == 0);
      4:       return act && (r == b);
      5:       return act && (c == a);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " locked"},     int'(locked),     0);
    check({tag, " pix_valid"},  int'(pix_valid),  0);
    check({tag, " pix_on"},     int'(pix_on),     0);
    check({tag, " pix_col"},    int'(pix_col),    0);
    check({tag, " pix_row"},    int'(pix_row),    0);
    check({tag, " frame_done"}, int'(frame_done), 0);
    check({tag, " frame_lit"},  int'(frame_lit),  0);
    check({tag, " err_count"},  int'(err_count),  0);
  endtask

  // One frame of stimulus starting at (0,0). early_row shifts that row's hs
  // pulse one clock early; rst_row pulses rst_n low in the middle of that row.
  task automatic send_frame(input int mode, input int a, input int b,
                            input int early_row, input int rst_row);
    for (int r = 0; r < VT_I; r++) begin
      for (int c = 0; c < HT_I; c++) begin
        int sh;
        @(posedge clk_25);
        #1;
        sh = (r == early_row) ? 1 : 0;
        vga_hs = !((c >= HSS_I - sh) && (c < HSE_I - sh));
        vga_vs = !((r >= VSS_I) && (r < VSE_I));
        vga_colors = lit_at(mode, c, r, a, b) ? (12'h001 << ((c + r) % 12)) : 12'h000;
        if (mode == 1 && c == a && r == b) mark_cyc = cyc;
        if (r == rst_row && c == 8) begin
          #2 rst_n = 1'b0;
          #1 check_reset_outputs("midframe reset");
        end
        if (r == rst_row && c == 11) rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0};
    vecs[1] = '{1, 5, 7, 1};
    vecs[2] = '{2, 0, 0, ACTIVE_PIX};
    vecs[3] = '{3, 0, 0, ACTIVE_PIX / 2};
    vecs[4] = '{4, 0, 3, HA_I};
    vecs[5] = '{1, HA_I - 1, VA_I - 1, 1};
    vecs[6] = '{1, 0, 0, 1};
    vecs[7] = '{5, 9, 0, VA_I};

    // Reset with busy inputs: every output must read 0.
    rst_n      = 1'b0;
    vga_colors = 12'hABC;
    vga_hs     = 1'b0;
    vga_vs     = 1'b1;
    repeat (3) @(posedge clk_25);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Acquisition frame: lock comes mid-frame, so no complete frame yet.
    snap();
    send_frame(0, 0, 0, -1, -1);
    check("acquire locked", int'(locked), 1);
    check("acquire no frame_done", fd_cnt - b_fd, 0);

    for (int i = 0; i < 8; i++) begin
      snap();
      send_frame(vecs[i].mode, vecs[i].a, vecs[i].b, -1, -1);
      check($sformatf("vec%0d frame_done count", i), fd_cnt - b_fd, 1);
      check($sformatf("vec%0d frame_lit at pulse", i), fd_lit, vecs[i].exp_lit);
      check($sformatf("vec%0d frame_lit held", i), int'(frame_lit), vecs[i].exp_lit);
      check($sformatf("vec%0d pix_on count", i), on_cnt - b_on, vecs[i].exp_lit);
      check($sformatf("vec%0d pix_valid count", i), val_cnt - b_val, ACTIVE_PIX);
      check($sformatf("vec%0d pix_on without valid", i), stray_cnt - b_stray, 0);
      check($sformatf("vec%0d locked", i), int'(locked), 1);
      if (i > 0) check($sformatf("vec%0d frame period", i), fd_cyc - prev_fd_cyc, FRAME_CYC);
      if (vecs[i].mode == 1) begin
        check($sformatf("vec%0d pix_col", i), on_col, vecs[i].a);
        check($sformatf("vec%0d pix_row", i), on_row, vecs[i].b);
        // Sample captured at the edge after drive, output two edges later.
        check($sformatf("vec%0d pix_on latency", i), on_cyc - mark_cyc, 3);
      end
      prev_fd_cyc = fd_cyc;
    end
    check("err_count after clean frames", int'(err_count), 0);

    // Reset in the middle of a frame discards it; the next full frame counts.
    snap();
    send_frame(2, 0, 0, -1, 4);
    check("reset frame no frame_done", fd_cnt - b_fd, 0);
    check("reset frame relocked", int'(locked), 1);
    snap();
    send_frame(2, 0, 0, -1, -1);
    check("post-reset frame_done count", fd_cnt - b_fd, 1);
    check("post-reset frame_lit", fd_lit, ACTIVE_PIX);

`ifdef VGA_RX_TIMING_CHECK_EN
    // hs pulse one clock early on row 2.
    snap();
    send_frame(0, 0, 0, 2, -1);
    check("hs early err_count", int'(err_count), 1);
    check("hs early lock dropped", (unl_cnt - b_unl > 0) ? 1 : 0, 1);
    check("hs early frame suppressed", fd_cnt - b_fd, 0);
    check("hs early relocked", int'(locked), 1);
    snap();
    send_frame(0, 0, 0, -1, -1);
    check("hs early recovery frame_done", fd_cnt - b_fd, 1);
    check("hs early recovery err_count", int'(err_count), 1);
    // Lit sample in horizontal blanking.
    snap();
    send_frame(1, HA_I + 4, 2, -1, -1);
    check("blank lit err_count", int'(err_count), 2);
    check("blank lit lock dropped", (unl_cnt - b_unl > 0) ? 1 : 0, 1);
    check("blank lit frame suppressed", fd_cnt - b_fd, 0);
    snap();
    send_frame(2, 0, 0, -1, -1);
    check("blank lit recovery frame_done", fd_cnt - b_fd, 1);
    check("blank lit recovery frame_lit", fd_lit, ACTIVE_PIX);
`else
    // Lit sample in horizontal blanking is ignored and keeps lock.
    snap();
    send_frame(1, HA_I + 4, 2, -1, -1);
    check("blank lit frame_done", fd_cnt - b_fd, 1);
    check("blank lit frame_lit", fd_lit, 0);
    check("blank lit pix_on count", on_cnt - b_on, 0);
    check("blank lit stays locked", unl_cnt - b_unl, 0);
    check("blank lit err_count", int'(err_count), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
